cpeta_err_eval: RTL and testbench

//  Self-running error-characterisation controller for the CPETA approximate adder.

---
 rtl/approx_eval_pkg.sv | 15 +
 rtl/cpeta_err_eval_adder.sv | 24 ++
 rtl/cpeta_err_eval.sv | 144 ++++++++++++++
 tb/tb_cpeta_err_eval.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_eval_pkg.sv
// Shared types and constants for the CPETA error-evaluation harness.
// Holds the controller state encoding and the operand LFSR step.
package approx_eval_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} eval_state_t;

   localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
   localparam logic [31:0] SEED_DEFAULT = 32'h1;

   // Right-shifting Galois form of x^32+x^22+x^2+x+1.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/cpeta_err_eval_adder.sv
// CPETA approximate adder: each sum bit sees a carry rippled only through the K bits
// directly below it, starting from an assumed carry-in of zero.
module cpeta_err_eval_adder #(
   parameter int N = 16,
   parameter int K = 6
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum
);

   always_comb begin
      logic c;
      sum = '0;
      for (int i = 0; i < N; i++) begin
         c = 1'b0;
         for (int j = 0; j < N; j++) begin
            if (j < i && j >= i - K) c = (a[j] & b[j]) | ((a[j] ^ b[j]) & c);
         end
         sum[i] = a[i] ^ b[i] ^ c;
      end
   end

endmodule

// File: rtl/cpeta_err_eval.sv
// On-chip error characterisation harness: drives CPETA and an exact adder in lock-step
// and accumulates error count, summed error distance and max error distance per run.
module cpeta_err_eval
   import approx_eval_pkg::*;
#(
   parameter int N     = 16,
   parameter int K     = 6,
   parameter int CNT_W = 16,
   parameter int ACC_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [CNT_W-1:0] num_samples,
   input  logic [31:0]      seed,
   input  logic [N-1:0]     op_a,
   input  logic [N-1:0]     op_b,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_ed,
   output logic [N-1:0]     max_ed
);

   localparam int SW = ((ACC_W > N) ? ACC_W : N) + 1;

   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [N-1:0]     ed);
      logic [SW-1:0] s;
      s = SW'(acc) + SW'(ed);
      if (s > SW'({ACC_W{1'b1}})) return '1;
      return s[ACC_W-1:0];
   endfunction

   eval_state_t      state, state_nxt;
   logic [CNT_W-1:0] remain;
   logic             drain_cnt, zero_pend;
   logic             accept, issue;
   logic             mode_q;
   logic [N-1:0]     op_a_q, op_b_q;
   logic [31:0]      lfsr, src_lfsr;
   logic             src_mode;
   logic [N-1:0]     a_nxt, b_nxt;
   logic [N-1:0]     a_p0, b_p0;
   logic             vld_p0;
   logic [N-1:0]     approx_c;
   logic [N-1:0]     exact_p1, approx_p1;
   logic             vld_p1;
   logic [N-1:0]     ed;

   // A zero-sample request parks one cycle in IDLE so done still rises one edge after start.
   assign accept = start && !zero_pend && (state == IDLE || state == DONE);
   assign issue  = (accept && num_samples != '0) || state == RUN;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE: begin
            if (state == IDLE && zero_pend)      state_nxt = DONE;
            else if (accept) begin
               if (num_samples == '0)             state_nxt = IDLE;
               else if (num_samples == CNT_W'(1)) state_nxt = DRAIN;
               else                               state_nxt = RUN;
            end
         end
         RUN:     if (remain == CNT_W'(1)) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
   end

   assign src_mode = accept ? mode : mode_q;
   assign src_lfsr = accept ? ((seed == 32'h0) ? SEED_DEFAULT : seed) : lfsr;
   assign a_nxt    = src_mode ? (accept ? op_a : op_a_q) : src_lfsr[N-1:0];
   assign b_nxt    = src_mode ? (accept ? op_b : op_b_q) : src_lfsr[16 +: N];

   always_ff @(posedge clk) begin
      if (rst) begin
         remain    <= '0;
         drain_cnt <= 1'b0;
         zero_pend <= 1'b0;
         lfsr      <= SEED_DEFAULT;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         zero_pend <= accept && num_samples == '0;
         drain_cnt <= (state == DRAIN) && !drain_cnt;
         if (accept)              remain <= num_samples - CNT_W'(1);
         else if (state == RUN)   remain <= remain - CNT_W'(1);
         if (issue)               lfsr   <= lfsr_step(src_lfsr);
         vld_p0 <= issue;
         vld_p1 <= vld_p0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         mode_q <= mode;
         op_a_q <= op_a;
         op_b_q <= op_b;
      end
      // p0: operand registers
      if (issue) begin
         a_p0 <= a_nxt;
         b_p0 <= b_nxt;
      end
      // p1: exact and approximate sums
      exact_p1  <= a_p0 + b_p0;
      approx_p1 <= approx_c;
   end

   cpeta_err_eval_adder #(.N(N), .K(K)) u_cpeta (
      .a   (a_p0),
      .b   (b_p0),
      .sum (approx_c)
   );

   assign ed = (exact_p1 >= approx_p1) ? exact_p1 - approx_p1 : approx_p1 - exact_p1;

   // p2: metric accumulation
   always_ff @(posedge clk) begin
      if (rst || accept) begin
         err_count <= '0;
         sum_ed    <= '0;
         max_ed    <= '0;
      end else if (vld_p1) begin
         if (ed != '0)    err_count <= err_count + CNT_W'(1);
         sum_ed <= sat_add(sum_ed, ed);
         if (ed > max_ed) max_ed <= ed;
      end
   end

endmodule

// File: tb/tb_cpeta_err_eval.sv
// Directed bench for cpeta_err_eval: hand-computed vectors plus a behavioural CPETA model
// for the LFSR runs; a second instance with an 8-bit accumulator covers saturation.
module tb_cpeta_err_eval;

   localparam int N = 16;
   localparam int K = 6;

   logic        clk = 1'b0;
   logic        rst, start, mode;
   logic [15:0] num_samples;
   logic [31:0] seed;
   logic [15:0] op_a, op_b;
   logic        busy, done, busy8, done8;
   logic [15:0] err_count, max_ed, err_count8, max_ed8;
   logic [31:0] sum_ed;
   logic [7:0]  sum_ed8;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cpeta_err_eval #(.N(16), .K(6), .CNT_W(16), .ACC_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples),
      .seed(seed), .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .err_count(err_count), .sum_ed(sum_ed), .max_ed(max_ed));

   cpeta_err_eval #(.N(16), .K(6), .CNT_W(16), .ACC_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .num_samples(num_samples),
      .seed(seed), .op_a(op_a), .op_b(op_b), .busy(busy8), .done(done8),
      .err_count(err_count8), .sum_ed(sum_ed8), .max_ed(max_ed8));

   // Carry into bit i is the carry-out of the arithmetic sum of the K-bit window below it.
   function automatic logic [15:0] model_approx(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] r;
      int lo, w, m, s, c;
      for (int i = 0; i < N; i++) begin
         lo = (i - K < 0) ? 0 : i - K;
         w  = i - lo;
         m  = (1 << w) - 1;
         s  = ((int'(a) >> lo) & m) + ((int'(b) >> lo) & m);
         c  = (s >> w) & 1;
         r[i] = a[i] ^ b[i] ^ c[0];
      end
      return r;
   endfunction

   task automatic model_run(input int s, input logic md, input logic [31:0] sd,
                            input logic [15:0] a, input logic [15:0] b,
                            output int ec, output longint se, output int me);
      logic [31:0] l;
      logic [15:0] aa, bb, ex, ap, ed;
      l  = (sd == 32'h0) ? 32'h1 : sd;
      ec = 0; se = 0; me = 0;
      for (int k = 0; k < s; k++) begin
         aa = md ? a : l[15:0];
         bb = md ? b : l[31:16];
         l  = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
         ex = aa + bb;
         ap = model_approx(aa, bb);
         ed = (ex >= ap) ? ex - ap : ap - ex;
         if (ed != 0) ec++;
         se = se + longint'(ed);
         if (se > 64'hFFFF_FFFF) se = 64'hFFFF_FFFF;
         if (int'(ed) > me) me = int'(ed);
      end
   endtask

   // Issues one run; lat is the edge count from start to done (-1 if done never came).
   task automatic do_run(input int s, input logic md, input logic [31:0] sd,
                         input logic [15:0] a, input logic [15:0] b, input int poke_k,
                         output int lat, output int busy_bad);
      @(negedge clk);
      num_samples = s[15:0]; mode = md; seed = sd; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; lat = -1; busy_bad = 0;
      if ((s == 0) ? (busy !== 1'b0) : (busy !== 1'b1)) busy_bad++;
      for (int k = 1; k <= s + 20; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) begin
            lat = k;
            if (busy !== 1'b0) busy_bad++;
            break;
         end
         if ((s == 0) ? (busy !== 1'b0) : (busy !== 1'b1)) busy_bad++;
         start = (k == poke_k);
         if (k == poke_k) begin
            num_samples = 16'd3; op_a = 16'h0F0F; op_b = 16'hF0F0; mode = 1'b1;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; mode = 1'b0; num_samples = '0; seed = '0; op_a = '0; op_b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (err_count !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 16'd0) begin
         bad++; $display("FAIL reset_metrics got=%0d/%0d/%0d want=0/0/0", err_count, sum_ed, max_ed); end
   endtask

   task automatic test_no_carry();
      int lat, bb;
      do_run(8, 1'b1, 32'h0, 16'h0F0F, 16'hF0F0, -1, lat, bb);
      total++; if (lat !== 9) begin bad++; $display("FAIL nocarry_latency got=%0d want=9", lat); end
      total++; if (bb !== 0) begin bad++; $display("FAIL nocarry_busy got=%0d bad cycles want=0", bb); end
      total++; if (err_count !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 16'd0) begin
         bad++; $display("FAIL nocarry_metrics got=%0d/%0d/%0d want=0/0/0", err_count, sum_ed, max_ed); end
   endtask

   task automatic test_long_carry();
      int lat, bb;
      // FFFF+0001: the carry dies after the 6-bit window, so approx=FF80 vs exact=0000.
      do_run(4, 1'b1, 32'h0, 16'hFFFF, 16'h0001, -1, lat, bb);
      total++; if (lat !== 5) begin bad++; $display("FAIL carry_latency got=%0d want=5", lat); end
      total++; if (err_count !== 16'd4) begin bad++; $display("FAIL carry_err_count got=%0d want=4", err_count); end
      total++; if (sum_ed !== 32'h0003_FE00) begin bad++; $display("FAIL carry_sum_ed got=%0h want=3fe00", sum_ed); end
      total++; if (max_ed !== 16'hFF80) begin bad++; $display("FAIL carry_max_ed got=%0h want=ff80", max_ed); end
      repeat (3) @(posedge clk); #1;
      total++; if (done !== 1'b1 || sum_ed !== 32'h0003_FE00 || err_count !== 16'd4) begin
         bad++; $display("FAIL carry_hold got=%0b/%0h/%0d want=1/3fe00/4", done, sum_ed, err_count); end
   endtask

   task automatic test_zero_samples();
      int lat, bb;
      do_run(0, 1'b1, 32'h0, 16'hFFFF, 16'h0001, -1, lat, bb);
      total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency got=%0d want=1", lat); end
      total++; if (bb !== 0) begin bad++; $display("FAIL zero_busy got=%0d bad cycles want=0", bb); end
      total++; if (err_count !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 16'd0) begin
         bad++; $display("FAIL zero_metrics got=%0d/%0d/%0d want=0/0/0", err_count, sum_ed, max_ed); end
   endtask

   task automatic test_lfsr_seed();
      int lat, bb, ec, me;
      longint se;
      logic [15:0] ec0, me0;
      logic [31:0] se0;
      do_run(1000, 1'b0, 32'h0, 16'h0, 16'h0, -1, lat, bb);
      ec0 = err_count; se0 = sum_ed; me0 = max_ed;
      total++; if (lat !== 1001) begin bad++; $display("FAIL lfsr_latency got=%0d want=1001", lat); end
      do_run(1000, 1'b0, 32'h1, 16'h0, 16'h0, -1, lat, bb);
      total++; if (ec0 !== err_count || se0 !== sum_ed || me0 !== max_ed) begin
         bad++; $display("FAIL seed0_vs_seed1 got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         ec0, se0, me0, err_count, sum_ed, max_ed); end
      model_run(1000, 1'b0, 32'h1, 16'h0, 16'h0, ec, se, me);
      total++; if (int'(err_count) !== ec || longint'(sum_ed) !== se || int'(max_ed) !== me) begin
         bad++; $display("FAIL lfsr_seed1_model got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         err_count, sum_ed, max_ed, ec, se, me); end
      do_run(500, 1'b0, 32'hDEAD_BEEF, 16'h0, 16'h0, -1, lat, bb);
      model_run(500, 1'b0, 32'hDEAD_BEEF, 16'h0, 16'h0, ec, se, me);
      total++; if (int'(err_count) !== ec || longint'(sum_ed) !== se || int'(max_ed) !== me) begin
         bad++; $display("FAIL lfsr_seedbeef_model got=%0d/%0d/%0d want=%0d/%0d/%0d",
                         err_count, sum_ed, max_ed, ec, se, me); end
   endtask

   task automatic test_start_ignored();
      int lat, bb;
      do_run(20, 1'b1, 32'h0, 16'hFFFF, 16'h0001, 5, lat, bb);
      total++; if (lat !== 21) begin bad++; $display("FAIL ignore_latency got=%0d want=21", lat); end
      total++; if (err_count !== 16'd20 || sum_ed !== 32'd1308160 || max_ed !== 16'hFF80) begin
         bad++; $display("FAIL ignore_metrics got=%0d/%0d/%0h want=20/1308160/ff80", err_count, sum_ed, max_ed); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bb, ec, me;
      longint se;
      @(negedge clk);
      num_samples = 16'd50; mode = 1'b0; seed = 32'h0000_0005; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL midrst_ctrl got busy=%0b done=%0b want=0/0", busy, done); end
      total++; if (err_count !== 16'd0 || sum_ed !== 32'd0 || max_ed !== 16'd0) begin
         bad++; $display("FAIL midrst_metrics got=%0d/%0d/%0d want=0/0/0", err_count, sum_ed, max_ed); end
      repeat (4) @(posedge clk); #1;
      total++; if (busy !== 1'b0 || done !== 1'b0 || err_count !== 16'd0 || sum_ed !== 32'd0) begin
         bad++; $display("FAIL midrst_quiet got=%0b/%0b/%0d/%0d want=0/0/0/0", busy, done, err_count, sum_ed); end
      do_run(50, 1'b0, 32'h0000_0005, 16'h0, 16'h0, -1, lat, bb);
      model_run(50, 1'b0, 32'h0000_0005, 16'h0, 16'h0, ec, se, me);
      total++; if (lat !== 51 || int'(err_count) !== ec || longint'(sum_ed) !== se || int'(max_ed) !== me) begin
         bad++; $display("FAIL midrst_rerun got=%0d/%0d/%0d/%0d want=51/%0d/%0d/%0d",
                         lat, err_count, sum_ed, max_ed, ec, se, me); end
   endtask

   task automatic test_saturation();
      int lat, bb;
      do_run(300, 1'b1, 32'h0, 16'hFFFF, 16'h0001, -1, lat, bb);
      total++; if (sum_ed8 !== 8'hFF) begin bad++; $display("FAIL sat8_sum_ed got=%0h want=ff", sum_ed8); end
      total++; if (err_count8 !== 16'd300 || max_ed8 !== 16'hFF80) begin
         bad++; $display("FAIL sat8_other got=%0d/%0h want=300/ff80", err_count8, max_ed8); end
      total++; if (sum_ed !== 32'd19622400) begin bad++; $display("FAIL sat32_sum_ed got=%0d want=19622400", sum_ed); end
      repeat (5) @(posedge clk); #1;
      total++; if (sum_ed8 !== 8'hFF || done8 !== 1'b1) begin
         bad++; $display("FAIL sat8_hold got=%0h/%0b want=ff/1", sum_ed8, done8); end
   endtask

   initial begin
      test_reset();
      test_no_carry();
      test_long_carry();
      test_zero_samples();
      test_lfsr_seed();
      test_start_ignored();
      test_reset_mid_run();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
